// File: rtl/set_time_ctrl.sv
// Set-time controller: captures the live BCD time, lets the user edit each field with
// buttons, clamps the day to the month length and pulses load on commit.
module set_time_ctrl #(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mode,
    input  logic        button_mid,
    input  logic        button_l,
    input  logic        button_r,
    input  logic [15:0] cur_year,
    input  logic [7:0]  cur_month,
    input  logic [7:0]  cur_day,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_minute,
    input  logic [7:0]  cur_sec,
    output logic [15:0] set_year,
    output logic [7:0]  set_month,
    output logic [7:0]  set_day,
    output logic [7:0]  set_hour,
    output logic [7:0]  set_minute,
    output logic [7:0]  set_sec,
    output logic        load,
    output logic        editing,
    output logic [2:0]  field_sel,
    output logic        blink
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [2:0] FIELD_LAST = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             mid_q, l_q, r_q;
    logic             mid_ev, l_ev, r_ev;
    logic [CNT_W-1:0] blink_cnt, cnt_nxt;
    logic             blink_nxt, load_nxt, editing_nxt;
    logic [2:0]       field_nxt;
    logic [15:0]      year_nxt;
    logic [7:0]       month_nxt, day_nxt, hour_nxt, minute_nxt, sec_nxt;
    logic [7:0]       day_max;

    // BCD increment/decrement with wrap inside [lo, hi]
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic up);
        logic [7:0] res;
        if (up) begin
            if (v >= hi)               res = lo;
            else if (v[3:0] >= 4'h9)   res = {v[7:4] + 4'h1, 4'h0};
            else                       res = v + 8'h01;
        end else begin
            if (v <= lo)               res = hi;
            else if (v[3:0] == 4'h0)   res = {v[7:4] - 4'h1, 4'h9};
            else                       res = v - 8'h01;
        end
        return res;
    endfunction

    // Last day of a month; leap test on the BCD year low byte (divisible by 4)
    function automatic logic [7:0] month_days(input logic [7:0] m, input logic [7:0] y);
        logic       leap;
        logic [7:0] res;
        leap = y[4] ? (y[3:0] == 4'h2 || y[3:0] == 4'h6)
                    : (y[3:0] == 4'h0 || y[3:0] == 4'h4 || y[3:0] == 4'h8);
        case (m)
            8'h02:                      res = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: res = 8'h30;
            default:                    res = 8'h31;
        endcase
        return res;
    endfunction

    assign mid_ev  = button_mid & ~mid_q;
    assign l_ev    = button_l & ~l_q;
    assign r_ev    = button_r & ~r_q;
    assign day_max = month_days(set_month, set_year[7:0]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mode == 4'd0 && mid_ev) state_nxt = EDIT;
            EDIT: begin
                if (mode != 4'd0)                            state_nxt = IDLE;
                else if (mid_ev && field_sel == FIELD_LAST)  state_nxt = COMMIT;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs; blink counter clears unless counting in EDIT
    always_comb begin
        year_nxt    = set_year;
        month_nxt   = set_month;
        day_nxt     = set_day;
        hour_nxt    = set_hour;
        minute_nxt  = set_minute;
        sec_nxt     = set_sec;
        field_nxt   = field_sel;
        load_nxt    = 1'b0;
        editing_nxt = (state_nxt == EDIT);
        cnt_nxt     = '0;
        blink_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (state_nxt == EDIT) begin
                    year_nxt   = cur_year;
                    month_nxt  = cur_month;
                    day_nxt    = cur_day;
                    hour_nxt   = cur_hour;
                    minute_nxt = cur_minute;
                    sec_nxt    = cur_sec;
                    field_nxt  = 3'd0;
                end
            end
            EDIT: begin
                if (state_nxt != EDIT) begin
                    field_nxt = 3'd0;
                end else if (mid_ev) begin
                    field_nxt = field_sel + 3'd1;
                end else begin
                    if (blink_cnt == CNT_LAST) begin
                        blink_nxt = ~blink;
                    end else begin
                        cnt_nxt   = blink_cnt + CNT_W'(1);
                        blink_nxt = blink;
                    end
                    // Simultaneous l and r cancel out
                    if (l_ev ^ r_ev) begin
                        case (field_sel)
                            3'd0: year_nxt   = {8'h20, bcd_step(set_year[7:0], 8'h00, 8'h99, r_ev)};
                            3'd1: month_nxt  = bcd_step(set_month,  8'h01, 8'h12, r_ev);
                            3'd2: day_nxt    = bcd_step(set_day,    8'h01, 8'h31, r_ev);
                            3'd3: hour_nxt   = bcd_step(set_hour,   8'h00, 8'h23, r_ev);
                            3'd4: minute_nxt = bcd_step(set_minute, 8'h00, 8'h59, r_ev);
                            3'd5: sec_nxt    = bcd_step(set_sec,    8'h00, 8'h59, r_ev);
                            default: ;
                        endcase
                    end
                end
            end
            COMMIT: begin
                if (set_day > day_max) day_nxt = day_max;
                load_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Output and button registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mid_q      <= 1'b0;
            l_q        <= 1'b0;
            r_q        <= 1'b0;
            set_year   <= 16'h2023;
            set_month  <= 8'h01;
            set_day    <= 8'h01;
            set_hour   <= 8'h00;
            set_minute <= 8'h00;
            set_sec    <= 8'h00;
            load       <= 1'b0;
            editing    <= 1'b0;
            field_sel  <= 3'd0;
            blink      <= 1'b0;
            blink_cnt  <= '0;
        end else begin
            mid_q      <= button_mid;
            l_q        <= button_l;
            r_q        <= button_r;
            set_year   <= year_nxt;
            set_month  <= month_nxt;
            set_day    <= day_nxt;
            set_hour   <= hour_nxt;
            set_minute <= minute_nxt;
            set_sec    <= sec_nxt;
            load       <= load_nxt;
            editing    <= editing_nxt;
            field_sel  <= field_nxt;
            blink      <= blink_nxt;
            blink_cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_set_time_ctrl.sv
// Directed bench for set_time_ctrl with hand-computed expectations (BLINK_DIV = 4).
module tb_set_time_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mode;
    logic        button_mid, button_l, button_r;
    logic [15:0] cur_year;
    logic [7:0]  cur_month, cur_day, cur_hour, cur_minute, cur_sec;
    logic [15:0] set_year;
    logic [7:0]  set_month, set_day, set_hour, set_minute, set_sec;
    logic        load, editing, blink;
    logic [2:0]  field_sel;

    int n_vec = 0;
    int n_bad = 0;
    int load_cnt = 0;
    int load_ref;

    set_time_ctrl #(.BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .button_mid(button_mid), .button_l(button_l), .button_r(button_r),
        .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_sec(cur_sec),
        .set_year(set_year), .set_month(set_month), .set_day(set_day),
        .set_hour(set_hour), .set_minute(set_minute), .set_sec(set_sec),
        .load(load), .editing(editing), .field_sel(field_sel), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load) load_cnt <= load_cnt + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One button pulse: high for one edge, low for the next
    task automatic press(input logic m, input logic l, input logic r);
        button_mid = m; button_l = l; button_r = r;
        tick();
        button_mid = 1'b0; button_l = 1'b0; button_r = 1'b0;
        tick();
    endtask

    task automatic press_n(input logic m, input logic l, input logic r, input int n);
        for (int i = 0; i < n; i++) press(m, l, r);
    endtask

    task automatic set_cur(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                           input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        cur_year = y; cur_month = mo; cur_day = d; cur_hour = h; cur_minute = mi; cur_sec = s;
    endtask

    initial begin
        rst = 1'b1; mode = 4'd0;
        button_mid = 1'b0; button_l = 1'b0; button_r = 1'b0;
        set_cur(16'h2023, 8'h05, 8'h10, 8'h12, 8'h30, 8'h45);
        repeat (3) @(posedge clk);
        #1;
        check("rst_year", set_year, 16'h2023);
        check("rst_month", 16'(set_month), 16'h01);
        check("rst_day", 16'(set_day), 16'h01);
        check("rst_hour", 16'(set_hour), 16'h00);
        check("rst_minute", 16'(set_minute), 16'h00);
        check("rst_sec", 16'(set_sec), 16'h00);
        check("rst_load", 16'(load), 16'h0);
        check("rst_editing", 16'(editing), 16'h0);
        check("rst_field", 16'(field_sel), 16'h0);
        check("rst_blink", 16'(blink), 16'h0);
        rst = 1'b0;
        tick();

        // Enter edit, capture live time
        press(1, 0, 0);
        check("enter_editing", 16'(editing), 16'h1);
        check("enter_field", 16'(field_sel), 16'h0);
        check("enter_year", set_year, 16'h2023);
        check("enter_month", 16'(set_month), 16'h05);
        check("enter_sec", 16'(set_sec), 16'h45);

        // Year wrap both ways
        press_n(0, 1, 0, 24);
        check("year_dec_wrap", set_year, 16'h2099);
        press(0, 0, 1);
        check("year_2099_inc", set_year, 16'h2000);
        press(0, 1, 0);
        check("year_2000_dec", set_year, 16'h2099);
        press_n(0, 0, 1, 24);
        check("year_back", set_year, 16'h2023);

        // Month
        press(1, 0, 0);
        check("field1", 16'(field_sel), 16'h1);
        press_n(0, 1, 0, 3);
        check("month_dec", 16'(set_month), 16'h02);
        press_n(0, 1, 0, 2);
        check("month_wrap_dn", 16'(set_month), 16'h12);
        press_n(0, 0, 1, 2);
        check("month_wrap_up", 16'(set_month), 16'h02);

        // Day, plus l+r cancel
        press(1, 0, 0);
        press_n(0, 1, 0, 10);
        check("day_wrap_dn", 16'(set_day), 16'h31);
        press(0, 1, 1);
        check("day_lr_same", 16'(set_day), 16'h31);

        // Hour, then mid+r together
        press(1, 0, 0);
        press_n(0, 0, 1, 12);
        check("hour_wrap_up", 16'(set_hour), 16'h00);
        press(0, 1, 0);
        check("hour_wrap_dn", 16'(set_hour), 16'h23);
        press(1, 0, 1);
        check("mid_r_field", 16'(field_sel), 16'h4);
        check("mid_r_hour", 16'(set_hour), 16'h23);
        check("mid_r_minute", 16'(set_minute), 16'h30);

        // Minute
        press_n(0, 0, 1, 30);
        check("minute_wrap_up", 16'(set_minute), 16'h00);
        press(0, 1, 0);
        check("minute_00_dec", 16'(set_minute), 16'h59);

        // Commit 2023-02-31 -> day 28
        load_ref = load_cnt;
        press(1, 0, 0);
        check("field5", 16'(field_sel), 16'h5);
        press(1, 0, 0);
        check("commit_load", 16'(load), 16'h1);
        check("commit_day28", 16'(set_day), 16'h28);
        check("commit_month", 16'(set_month), 16'h02);
        check("commit_editing", 16'(editing), 16'h0);
        tick();
        check("load_drop", 16'(load), 16'h0);
        check("load_once", 16'(load_cnt - load_ref), 16'h1);

        // Leap year 2024-02-31 -> 29
        set_cur(16'h2024, 8'h02, 8'h31, 8'h00, 8'h00, 8'h00);
        press(1, 0, 0);
        press_n(1, 0, 0, 5);
        check("leap_field5", 16'(field_sel), 16'h5);
        press(1, 0, 0);
        check("leap_load", 16'(load), 16'h1);
        check("leap_day29", 16'(set_day), 16'h29);

        // 30-day month 2023-04-31 -> 30
        set_cur(16'h2023, 8'h04, 8'h31, 8'h00, 8'h00, 8'h00);
        press_n(1, 0, 0, 7);
        check("apr_load", 16'(load), 16'h1);
        check("apr_day30", 16'(set_day), 16'h30);
        tick();

        // Abort at field 3
        load_ref = load_cnt;
        press_n(1, 0, 0, 4);
        check("abort_field3", 16'(field_sel), 16'h3);
        press(0, 0, 1);
        check("abort_hour_inc", 16'(set_hour), 16'h01);
        mode = 4'd1;
        tick();
        check("abort_editing", 16'(editing), 16'h0);
        check("abort_field", 16'(field_sel), 16'h0);
        check("abort_hour_kept", 16'(set_hour), 16'h01);
        mode = 4'd0;
        tick();
        tick();
        check("abort_no_load", 16'(load_cnt - load_ref), 16'h0);

        // mid ignored in IDLE when mode != 0
        mode = 4'd2;
        press(1, 0, 0);
        check("mode2_idle", 16'(editing), 16'h0);
        mode = 4'd0;

        // Blink period 4, cleared by mid
        press(1, 0, 0);
        tick(); tick();
        check("blink_e3", 16'(blink), 16'h0);
        tick();
        check("blink_e4", 16'(blink), 16'h1);
        tick(); tick(); tick();
        check("blink_e7", 16'(blink), 16'h1);
        tick();
        check("blink_e8", 16'(blink), 16'h0);
        repeat (4) tick();
        check("blink_e12", 16'(blink), 16'h1);
        press(1, 0, 0);
        check("blink_mid_clr", 16'(blink), 16'h0);
        tick(); tick();
        check("blink_restart_3", 16'(blink), 16'h0);
        tick();
        check("blink_restart_4", 16'(blink), 16'h1);
        mode = 4'd1;
        tick();
        check("blink_leave", 16'(blink), 16'h0);
        mode = 4'd0;
        tick();

        // Reset mid-edit discards, held button fires after release
        load_ref = load_cnt;
        press(1, 0, 0);
        press(0, 0, 1);
        check("pre_rst_year", set_year, 16'h2024);
        rst = 1'b1;
        #1;
        check("rst_async_year", set_year, 16'h2023);
        check("rst_async_edit", 16'(editing), 16'h0);
        button_mid = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("held_btn_event", 16'(editing), 16'h1);
        button_mid = 1'b0;
        mode = 4'd1;
        tick();
        mode = 4'd0;
        tick();
        check("rst_no_load", 16'(load_cnt - load_ref), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
